output_stream_buffer: RTL

OUTPUT_STREAM_BUFFER -- requirements
Module: output_stream_buffer

---
 rtl/output_stream_buffer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/output_stream_buffer.sv
// -----------------------------------------------------------------------------
// output_stream_buffer
//   Requantizes accumulator results from the convolution controller, buffers
//   them with their coordinates in a first-word-fall-through FIFO and streams
//   them to the host with a valid/ready handshake. Tracks how many words of
//   the current layer have been delivered and reports completion.
//
// Ports
//   clk           single clock, rising edge
//   arst_n_in     asynchronous reset, active low
//   start         begin a new layer; flushes stage register, FIFO and counters
//   in_valid      accumulator result present (controller output_valid)
//   in_data       signed accumulator result, ACC_WIDTH bits
//   in_x/y/ch     result coordinates, 32 bits each
//   almost_full   registered stall request to the upstream controller
//   out_valid     head word available to the host
//   out_ready     host accepts the head word
//   out_data      requantized signed head word, OUT_WIDTH bits
//   out_x/y/ch    coordinates of out_data
//   busy          layer in progress
//   done          every result of the layer has been delivered
//   overflow      sticky: a result was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module output_stream_buffer #(
  parameter int ACC_WIDTH          = 32,
  parameter int OUT_WIDTH          = 16,
  parameter int SHIFT              = 8,
  parameter int DEPTH              = 16,
  parameter int AF_MARGIN          = 6,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [ACC_WIDTH-1:0] in_data,
  input  logic [31:0]          in_x,
  input  logic [31:0]          in_y,
  input  logic [31:0]          in_ch,
  output logic                 almost_full,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [31:0]          out_x,
  output logic [31:0]          out_y,
  output logic [31:0]          out_ch,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // FIFO entry layout: {data, x, y, ch}
  localparam int EW = OUT_WIDTH + 96;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL_C = CW'(DEPTH - AF_MARGIN);
  localparam logic [31:0]   TOTAL_C    = 32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);
  localparam logic [31:0]   TOTAL_M1_C = TOTAL_C - 32'd1;

  localparam logic [ACC_WIDTH:0] RND_C = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX_C =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN_C =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Round-half-up, arithmetic shift, saturate. One extra bit keeps the
  // rounding addition from wrapping at the positive extreme.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] shifted;
    logic [OUT_WIDTH-1:0]      res;
    sum     = $signed({acc[ACC_WIDTH-1], acc}) + $signed(RND_C);
    shifted = sum >>> SHIFT;
    if (shifted > SAT_MAX_C) begin
      res = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    end else if (shifted < SAT_MIN_C) begin
      res = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
    end else begin
      res = shifted[OUT_WIDTH-1:0];
    end
    return res;
  endfunction

  logic [1:0]    state_r, state_nxt_s;
  logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s, remain_s;
  logic          stage_valid_r;
  logic [EW-1:0] stage_entry_r;
  logic [EW-1:0] mem_r [DEPTH];
  logic [EW-1:0] head_r, head_nxt_s;
  logic [31:0]   pop_cnt_r, pop_cnt_nxt_s;
  logic          pop_s, push_ok_s, push_wr_s, ovf_set_s, overflow_nxt_s;
  logic          overflow_r, out_valid_r, almost_full_r, busy_r, done_r;

  // FIFO bookkeeping, head prefetch, pop counter and layer state machine
  always_comb begin
    pop_s        = (count_r != {CW{1'b0}}) & out_ready;
    // A full FIFO still takes a push when the head leaves on the same edge
    push_ok_s    = stage_valid_r & ((count_r < DEPTH_C) | pop_s);
    ovf_set_s    = stage_valid_r & ~push_ok_s;
    remain_s     = count_r - {{(CW - 1){1'b0}}, pop_s};
    rd_ptr_nxt_s = rd_ptr_r + {{(AW - 1){1'b0}}, pop_s};
    wr_ptr_nxt_s = wr_ptr_r + {{(AW - 1){1'b0}}, push_ok_s};
    count_nxt_s  = remain_s + {{(CW - 1){1'b0}}, push_ok_s};
    push_wr_s    = push_ok_s & ~start;
    overflow_nxt_s = overflow_r | ovf_set_s;

    // Registered head: an older entry takes over if one remains, otherwise
    // the entry being pushed becomes the head of an otherwise empty FIFO.
    if (remain_s != {CW{1'b0}}) begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end else if (push_ok_s) begin
      head_nxt_s = stage_entry_r;
    end else begin
      head_nxt_s = head_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else if (pop_s && (pop_cnt_r == TOTAL_M1_C)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    if ((state_r == ST_RUN) && pop_s) begin
      pop_cnt_nxt_s = pop_cnt_r + 32'd1;
    end else begin
      pop_cnt_nxt_s = pop_cnt_r;
    end

    // start flushes everything; an entry in flight on this edge is lost
    if (start) begin
      rd_ptr_nxt_s   = {AW{1'b0}};
      wr_ptr_nxt_s   = {AW{1'b0}};
      count_nxt_s    = {CW{1'b0}};
      head_nxt_s     = head_r;
      pop_cnt_nxt_s  = 32'd0;
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r | ovf_set_s;
    end
  end

  // Stage register: requantized result and coordinates
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      stage_valid_r <= 1'b0;
      stage_entry_r <= {EW{1'b0}};
    end else begin
      stage_valid_r <= in_valid & (state_r == ST_RUN) & ~start;
      if (in_valid) begin
        stage_entry_r <= {requant(in_data), in_x, in_y, in_ch};
      end
    end
  end

  // FIFO storage; contents are meaningless outside the pointer window
  always_ff @(posedge clk) begin
    if (push_wr_s) begin
      mem_r[wr_ptr_r] <= stage_entry_r;
    end
  end

  // FIFO control, state and registered status outputs
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_r       <= ST_IDLE;
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      head_r        <= {EW{1'b0}};
      pop_cnt_r     <= 32'd0;
      overflow_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      almost_full_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
      count_r       <= count_nxt_s;
      head_r        <= head_nxt_s;
      pop_cnt_r     <= pop_cnt_nxt_s;
      overflow_r    <= overflow_nxt_s;
      out_valid_r   <= (count_nxt_s != {CW{1'b0}});
      almost_full_r <= (count_nxt_s >= AF_LEVEL_C);
      busy_r        <= (state_nxt_s == ST_RUN);
      done_r        <= (state_nxt_s == ST_DONE);
    end
  end

  assign out_data    = head_r[EW-1 -: OUT_WIDTH];
  assign out_x       = head_r[95:64];
  assign out_y       = head_r[63:32];
  assign out_ch      = head_r[31:0];
  assign out_valid   = out_valid_r;
  assign almost_full = almost_full_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign overflow    = overflow_r;

endmodule
